// File: rtl/sample_serializer.sv
// -----------------------------------------------------------------------------
// sample_serializer
//
// Frames 16-bit two's-complement samples onto a three-wire serial link
// (sclk / fsync / sdata).
//
// Each frame is FRAME_BITS bit periods of BIT_DIV clocks each. At every frame
// start the block pulses generate_next_sample to the upstream sample chain.
// SAMPLE_LATENCY clocks later it captures sample_in, or zero when mute is
// high, into a holding register. That captured sample goes out MSB first in
// the following frame. Bits 16..FRAME_BITS-1 of every frame are zero.
//
// Parameters
//   BIT_DIV         clocks per serial bit (even, >= 2)
//   FRAME_BITS      serial bits per frame (>= 17)
//   SAMPLE_LATENCY  clocks from strobe to capture (1 .. FRAME_BITS*BIT_DIV-1)
//
// Ports
//   clk                   in   single clock, rising edge
//   reset                 in   asynchronous, active-high reset
//   enable                in   1 = run frames, 0 = finish current frame and stop
//   mute                  in   1 on the capture clock = capture zero
//   sample_in[15:0]       in   sample from the synth chain
//   generate_next_sample  out  one-clock request strobe at each frame start
//   sclk                  out  bit clock, low in first half of each bit period
//   fsync                 out  high during bit 0 of each frame
//   sdata                 out  serial data, MSB first, changes as sclk falls
//   busy                  out  high while a frame is in progress (RUN/DRAIN)
//
// All outputs come straight from flops. They are loaded from the next-state
// values, so each output lines up with the counter position it describes.
// -----------------------------------------------------------------------------
module sample_serializer #(
  parameter int BIT_DIV        = 2,
  parameter int FRAME_BITS     = 20,
  parameter int SAMPLE_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mute,
  input  logic [15:0] sample_in,
  output logic        generate_next_sample,
  output logic        sclk,
  output logic        fsync,
  output logic        sdata,
  output logic        busy
);

  localparam int DIV_W = $clog2(BIT_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BIT_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(16);

  // Frame position of the capture clock, split into bit and sub-bit parts.
  localparam logic [BIT_W-1:0] CAP_BIT = BIT_W'(SAMPLE_LATENCY / BIT_DIV);
  localparam logic [DIV_W-1:0] CAP_DIV = DIV_W'(SAMPLE_LATENCY % BIT_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic [15:0]      shift_q, shift_d;
  logic [15:0]      hold_q,  hold_d;
  logic             armed_q, armed_d;   // strobe issued, capture still pending
  logic             bit_end;
  logic             frame_end;
  logic             capture;
  logic             busy_d;

  // NOTE: every signal gets a default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    armed_d   = armed_q;

    bit_end   = (div_q == DIV_LAST);
    frame_end = bit_end && (bit_q == BIT_LAST);
    capture   = armed_q && (bit_q == CAP_BIT) && (div_q == CAP_DIV);

    // Capture depends only on a strobe having gone out earlier in this frame.
    // A capture that is still pending during DRAIN therefore still happens.
    if (capture) begin
      hold_d  = mute ? 16'h0000 : sample_in;
      armed_d = 1'b0;
    end
    if (generate_next_sample) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          div_d   = '0;
          bit_d   = '0;
          shift_d = hold_q;
        end
      end
      default: begin  // RUN or DRAIN: counters keep running
        // Dropping enable moves to DRAIN. Raising it again returns to RUN
        // without disturbing the counters. IDLE is entered only at the wrap.
        state_d = enable ? RUN : (frame_end ? IDLE : DRAIN);
        div_d   = bit_end ? '0 : div_q + 1'b1;
        if (bit_end) begin
          bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        end
        // hold_d, not hold_q: a capture on the very last clock of the frame
        // must still reach the next frame.
        if (frame_end && enable) begin
          shift_d = hold_d;
        end else if (bit_end) begin
          shift_d = {shift_q[14:0], 1'b0};
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      div_q                <= '0;
      bit_q                <= '0;
      shift_q              <= '0;
      // NOTE: the holding register is data storage, but it is reset on
      // purpose. The first frame after reset must send a known zero sample.
      hold_q               <= '0;
      armed_q              <= 1'b0;
      generate_next_sample <= 1'b0;
      sclk                 <= 1'b0;
      fsync                <= 1'b0;
      sdata                <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state_q              <= state_d;
      div_q                <= div_d;
      bit_q                <= bit_d;
      shift_q              <= shift_d;
      hold_q               <= hold_d;
      armed_q              <= armed_d;
      generate_next_sample <= (state_d == RUN) && (bit_d == '0) && (div_d == '0);
      sclk                 <= busy_d && (div_d >= DIV_HALF);
      fsync                <= busy_d && (bit_d == '0);
      sdata                <= busy_d && (bit_d < DATA_BITS) && shift_d[15];
      busy                 <= busy_d;
    end
  end

endmodule
